// File: rtl/nxm_queue_pkg.sv
// Shared definitions for the multichannel queue: operation decode and width helpers.
`timescale 1ns/1ps
package nxm_queue_pkg;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_PUSHPOP = 3'd3,
        OP_TOP     = 3'd4,
        OP_PUSHTOP = 3'd5
    } op_e;

    // Number of bits to index n items, never less than one.
    function automatic int width_of(input int n);
        int w;
        if (n < 2) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

    // Dequeue outranks top; enqueue combines with either.
    function automatic op_e decode_op(input logic enq, input logic deq, input logic peek);
        op_e op;
        if (enq && deq) begin
            op = OP_PUSHPOP;
        end else if (deq) begin
            op = OP_POP;
        end else if (enq && peek) begin
            op = OP_PUSHTOP;
        end else if (enq) begin
            op = OP_PUSH;
        end else if (peek) begin
            op = OP_TOP;
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/nxm_queue_channel.sv
// One FIFO channel: storage, head/tail pointers, occupancy, status flags and sticky errors.
`timescale 1ns/1ps
module nxm_queue_channel
    import nxm_queue_pkg::*;
#(
    parameter int BITWIDTH    = 8,
    parameter int QUEUESIZE   = 8,
    parameter int AFULL_LEVEL = QUEUESIZE - 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  sel,
    input  op_e                                   op,
    input  logic                                  clear_err,
    input  logic [BITWIDTH-1:0]                   data_in,
    output logic [BITWIDTH-1:0]                   head,
    output logic [width_of(QUEUESIZE + 1)-1:0]    count_next,
    output logic                                  empty,
    output logic                                  full,
    output logic                                  almost_full,
    output logic                                  overflow,
    output logic                                  underflow
);

    localparam int CNT_W = width_of(QUEUESIZE + 1);
    localparam int PTR_W = width_of(QUEUESIZE);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(QUEUESIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(QUEUESIZE);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_LEVEL);

    logic [BITWIDTH-1:0] mem_r [QUEUESIZE];
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [PTR_W-1:0]    head_nxt_s;
    logic [PTR_W-1:0]    tail_nxt_s;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_nxt_s;
    logic                empty_r;
    logic                full_r;
    logic                afull_r;
    logic                ovf_r;
    logic                unf_r;
    logic                ovf_nxt_s;
    logic                unf_nxt_s;
    logic                push_req_s;
    logic                pop_req_s;
    logic                do_push_s;
    logic                do_pop_s;

    // Split the decoded operation into push and pop requests.
    always_comb begin
        push_req_s = 1'b0;
        pop_req_s  = 1'b0;
        case (op)
            OP_PUSH, OP_PUSHTOP: push_req_s = 1'b1;
            OP_POP:              pop_req_s  = 1'b1;
            OP_PUSHPOP: begin
                push_req_s = 1'b1;
                pop_req_s  = 1'b1;
            end
            default: begin
                push_req_s = 1'b0;
                pop_req_s  = 1'b0;
            end
        endcase
    end

    // Next pointers, occupancy and sticky errors; a full channel still accepts a push paired with a pop.
    always_comb begin
        do_push_s  = sel && push_req_s && (!full_r || pop_req_s);
        do_pop_s   = sel && pop_req_s && !empty_r;
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        if (do_pop_s) begin
            head_nxt_s = (head_r == PTR_LAST) ? {PTR_W{1'b0}} : head_r + PTR_W'(1);
        end else begin
            head_nxt_s = head_r;
        end
        if (do_push_s) begin
            tail_nxt_s = (tail_r == PTR_LAST) ? {PTR_W{1'b0}} : tail_r + PTR_W'(1);
        end else begin
            tail_nxt_s = tail_r;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        // A fresh error outranks a same-cycle clear.
        if (sel && push_req_s && !do_push_s) begin
            ovf_nxt_s = 1'b1;
        end else if (sel && clear_err) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
        if (sel && pop_req_s && empty_r) begin
            unf_nxt_s = 1'b1;
        end else if (sel && clear_err) begin
            unf_nxt_s = 1'b0;
        end else begin
            unf_nxt_s = unf_r;
        end
    end

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[tail_r] <= data_in;
        end
    end

    // Pointer, count, flag and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            afull_r <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {CNT_W{1'b0}});
            full_r  <= (count_nxt_s == CNT_FULL);
            afull_r <= (count_nxt_s >= CNT_AFULL);
            ovf_r   <= ovf_nxt_s;
            unf_r   <= unf_nxt_s;
        end
    end

    assign head        = mem_r[head_r];
    assign count_next  = count_nxt_s;
    assign empty       = empty_r;
    assign full        = full_r;
    assign almost_full = afull_r;
    assign overflow    = ovf_r;
    assign underflow   = unf_r;

endmodule

// File: rtl/nxm_multichannel_queue.sv
// Multichannel queue top: decodes the shared operation port, fans it out to per-channel
// FIFOs and registers the read data, read strobe and selected-channel occupancy.
`timescale 1ns/1ps
module nxm_multichannel_queue
    import nxm_queue_pkg::*;
#(
    parameter int BITWIDTH    = 8,
    parameter int QUEUESIZE   = 8,
    parameter int CHANNELS    = 4,
    parameter int AFULL_LEVEL = QUEUESIZE - 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enable,
    input  logic [width_of(CHANNELS)-1:0]         ch_sel,
    input  logic                                  enqueue,
    input  logic                                  dequeue,
    input  logic                                  top,
    input  logic                                  clear_err,
    input  logic [BITWIDTH-1:0]                   data_in,
    output logic [BITWIDTH-1:0]                   data_out,
    output logic                                  data_valid,
    output logic [width_of(QUEUESIZE + 1)-1:0]    sel_count,
    output logic [CHANNELS-1:0]                   empty,
    output logic [CHANNELS-1:0]                   full,
    output logic [CHANNELS-1:0]                   almost_full,
    output logic [CHANNELS-1:0]                   overflow,
    output logic [CHANNELS-1:0]                   underflow
);

    localparam int CH_W  = width_of(CHANNELS);
    localparam int CNT_W = width_of(QUEUESIZE + 1);

    op_e                 op_s;
    logic [CHANNELS-1:0] sel_s;
    logic                hit_s;
    logic                read_req_s;
    logic                valid_s;
    logic                empty_sel_s;
    logic [BITWIDTH-1:0] head_sel_s;
    logic [CNT_W-1:0]    cnt_sel_s;
    logic [BITWIDTH-1:0] head_s [CHANNELS];
    logic [CNT_W-1:0]    cnt_nxt_s [CHANNELS];
    logic [BITWIDTH-1:0] data_out_r;
    logic                data_valid_r;
    logic [CNT_W-1:0]    sel_count_r;

    // Channel select decode and head/count mux; out-of-range ch_sel selects nothing.
    always_comb begin
        op_s        = decode_op(enqueue, dequeue, top);
        sel_s       = {CHANNELS{1'b0}};
        head_sel_s  = {BITWIDTH{1'b0}};
        cnt_sel_s   = {CNT_W{1'b0}};
        empty_sel_s = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            sel_s[c]    = enable && (ch_sel == CH_W'(c));
            head_sel_s  = head_sel_s | (sel_s[c] ? head_s[c] : {BITWIDTH{1'b0}});
            cnt_sel_s   = cnt_sel_s | (sel_s[c] ? cnt_nxt_s[c] : {CNT_W{1'b0}});
            empty_sel_s = empty_sel_s & (!sel_s[c] || empty[c]);
        end
        hit_s = |sel_s;
    end

    // Operations that present the head on data_out.
    always_comb begin
        case (op_s)
            OP_POP, OP_PUSHPOP, OP_TOP, OP_PUSHTOP: read_req_s = 1'b1;
            default:                                read_req_s = 1'b0;
        endcase
        valid_s = hit_s && read_req_s && !empty_sel_s;
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            nxm_queue_channel #(
                .BITWIDTH   (BITWIDTH),
                .QUEUESIZE  (QUEUESIZE),
                .AFULL_LEVEL(AFULL_LEVEL)
            ) u_channel (
                .clk        (clk),
                .rst_n      (rst_n),
                .sel        (sel_s[g]),
                .op         (op_s),
                .clear_err  (clear_err),
                .data_in    (data_in),
                .head       (head_s[g]),
                .count_next (cnt_nxt_s[g]),
                .empty      (empty[g]),
                .full       (full[g]),
                .almost_full(almost_full[g]),
                .overflow   (overflow[g]),
                .underflow  (underflow[g])
            );
        end
    endgenerate

    // Output registers; data_out and sel_count hold when nothing updates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r   <= {BITWIDTH{1'b0}};
            data_valid_r <= 1'b0;
            sel_count_r  <= {CNT_W{1'b0}};
        end else begin
            data_valid_r <= valid_s;
            if (valid_s) begin
                data_out_r <= head_sel_s;
            end
            if (hit_s) begin
                sel_count_r <= cnt_sel_s;
            end
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign sel_count  = sel_count_r;

endmodule

// File: doc/nxm_multichannel_queue.md
Name: nxm_multichannel_queue

Overview:
- Next-generation N-bit x M-deep queue with CHANNELS independent FIFO channels behind one shared operation port.
- Adds the following per channel:
  - simultaneous enqueue/dequeue
  - occupancy count
  - almost-full threshold
  - sticky overflow/underflow errors with explicit clear
- Sits between a single producer/consumer agent and per-channel consumers; one operation slot per clock, addressed by ch_sel.

Parameters:
- BITWIDTH, 8, data word width.
- QUEUESIZE, 8, entries per channel; ≥2; need not be a power of 2.
- CHANNELS, 4, number of independent queues; ≥1.
- AFULL_LEVEL, QUEUESIZE-1, almost_full[c] asserts when count[c] ≥ AFULL_LEVEL.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  global operation enable.
- ch_sel  in  CH_W=max(1,$clog2(CHANNELS))  target channel.
- enqueue  in  1  push data_in into ch_sel.
- dequeue  in  1  pop head of ch_sel to data_out.
- top  in  1  peek head of ch_sel to data_out without removal.
- clear_err  in  1  clear sticky error flags of ch_sel.
- data_in  in  BITWIDTH  enqueue data.
- data_out  out  BITWIDTH  registered head data.
- data_valid  out  1  data_out updated this cycle (one-cycle pulse).
- sel_count  out  CNT_W=$clog2(QUEUESIZE+1)  registered occupancy of channel selected last cycle.
- empty  out  CHANNELS  per-channel empty.
- full  out  CHANNELS  per-channel full.
- almost_full  out  CHANNELS  per-channel count ≥ AFULL_LEVEL.
- overflow  out  CHANNELS  sticky: enqueue rejected.
- underflow  out  CHANNELS  sticky: dequeue rejected.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low clears all pointers and counts immediately, including mid-operation.
  - Outputs after reset: data_out=0, data_valid=0, sel_count=0, empty=all 1, full/almost_full/overflow/underflow=all 0.
  - Storage contents are don't-care.
- enable=0 or ch_sel ≥ CHANNELS:
  - no state change; data_valid=0 next cycle; data_out, flags and counts hold.
  - clear_err is ignored.
- Operations on channel c=ch_sel at the rising edge, all results visible 1 cycle later:
  - enqueue only: if !full[c], write at tail, tail wraps mod QUEUESIZE, count+1. If full[c], drop the data and set overflow[c].
  - dequeue only: if !empty[c], data_out ← head, data_valid=1, head wraps, count-1. If empty[c], set underflow[c], data_valid=0, data_out holds.
  - enqueue+dequeue, count>0 (including full): both execute; count unchanged; no overflow.
  - enqueue+dequeue, empty: enqueue executes, dequeue rejected (underflow[c]=1, no bypass); count=1.
  - top (dequeue=0): if !empty[c], data_out ← head, data_valid=1, no pointer change; if empty[c], data_valid=0, no error.
  - top with dequeue: dequeue takes precedence; top ignored.
  - top with enqueue: both execute; data_out is the pre-enqueue head.
- Flag timing:
  - empty/full/almost_full are registered and reflect the post-operation count.
  - Channels not selected are unaffected.
- Sticky errors:
  - clear_err clears overflow[c] and underflow[c].
  - A new error in the same cycle as clear_err wins (flag stays 1).
- sel_count is the registered count of the channel addressed in the previous enabled cycle, post-operation.
- Arithmetic:
  - Pointers are $clog2(QUEUESIZE) bits and wrap explicitly at QUEUESIZE-1 → 0.
  - count saturates logically at 0..QUEUESIZE; never wraps.

Decomposition:
- Package nxm_queue_pkg holds:
  - op-decode enum (OP_NONE, OP_PUSH, OP_POP, OP_PUSHPOP, OP_TOP, OP_PUSHTOP)
  - width helper function for CNT_W/CH_W
- Sub-module nxm_queue_channel: one channel's storage, head/tail pointers, count, flag and error registers.
  - Instantiated CHANNELS times in a generate loop.
- The top level does the ch_sel decode, muxes head data, and registers data_out, data_valid and sel_count.

Test Plan (BITWIDTH=3, QUEUESIZE=8, CHANNELS=2, AFULL_LEVEL=6):
- Reset, then push 0..7 into ch0 → after 6th push almost_full[0]=1; after 8th full[0]=1, sel_count=8; ch1 stays empty=1.
- 9th push (data 5) to full ch0 → overflow[0]=1, count stays 8; clear_err on ch0 → overflow[0]=0.
- top then dequeue ch0 ×8 → data_out sequence 0,0,1,2..7 (top shows 0, first pop 0), data_valid pulses; empty[0]=1 at end; 9th dequeue → underflow[0]=1, data_valid=0.
- Interleave: push 3 to ch1, push 4 to ch0, pop ch1 → data_out=3; ch0 count=1; ch1 empty=1.
- Simultaneous enqueue+dequeue on full ch0 (data 6) → data_out=old head, count stays 8, overflow=0; same on empty ch1 → count=1, underflow[1]=1.
- Assert rst_n low mid-push burst, asynchronous to clk → all counts 0, empty=all 1, data_valid=0 before the next edge.
